// File: rtl/pcie_seq_pkg.sv
// Shared types and helpers for the PCIe link reset sequencer.
// Global/per-link state encodings and the lane-mask helper.
package pcie_seq_pkg;

    localparam int WSEL_W   = 3;
    localparam int LANE_MAX = 128;

    typedef enum logic [1:0] {
        G_RST,
        G_WAIT,
        G_REL,
        G_RUN
    } gstate_t;

    typedef enum logic [1:0] {
        L_HELD,
        L_DETECT,
        L_UP
    } lstate_t;

    function automatic logic [LANE_MAX-1:0] lane_mask(
        input logic [WSEL_W-1:0] wsel,
        input int                width
    );
        int n;
        n = 1 << wsel;
        if (n > width) n = width;
        lane_mask = '0;
        for (int i = 0; i < LANE_MAX; i++)
            if (i < n) lane_mask[i] = 1'b1;
    endfunction

endpackage

// File: rtl/pcie_link_fsm.sv
// Per-link HELD/DETECT/UP sequencer with hold and detect counters.
// Lane enables double as the latched lane mask while out of HELD.
module pcie_link_fsm
    import pcie_seq_pkg::*;
#(
    parameter int LINK_WIDTH    = 1,
    parameter int T_STAGGER_CYC = 4,
    parameter int DET_CYC       = 8,
    parameter int CW            = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  link_en,
    input  logic                  hot_rst_req,
    input  logic                  rel_req,
    input  logic                  run,
    input  logic [WSEL_W-1:0]     width_sel,
    input  logic [LINK_WIDTH-1:0] rx_valid,
    output logic                  link_perst_n,
    output logic [LINK_WIDTH-1:0] lane_en,
    output logic                  link_up
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(T_STAGGER_CYC - 1);
    localparam logic [CW-1:0] DET_LAST  = CW'(DET_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    lstate_t               state;
    logic [CW-1:0]         hold_cnt;
    logic [CW-1:0]         det_cnt;
    logic [LINK_WIDTH-1:0] new_mask;
    logic                  all_ok;

    assign new_mask = LINK_WIDTH'(lane_mask(width_sel, LINK_WIDTH));
    assign all_ok   = &(rx_valid | ~lane_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= L_HELD;
            hold_cnt     <= '0;
            det_cnt      <= '0;
            link_perst_n <= 1'b0;
            lane_en      <= '0;
            link_up      <= 1'b0;
        end else if (hot_rst_req || !link_en) begin
            state        <= L_HELD;
            hold_cnt     <= '0;
            det_cnt      <= '0;
            link_perst_n <= 1'b0;
            lane_en      <= '0;
            link_up      <= 1'b0;
        end else begin
            unique case (state)
                L_HELD: begin
                    if (rel_req || (run && hold_cnt >= HOLD_LAST)) begin
                        state        <= L_DETECT;
                        hold_cnt     <= '0;
                        det_cnt      <= '0;
                        link_perst_n <= 1'b1;
                        lane_en      <= new_mask;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                L_DETECT: begin
                    if (!all_ok) begin
                        det_cnt <= '0;
                    end else if (det_cnt >= DET_LAST) begin
                        state   <= L_UP;
                        link_up <= 1'b1;
                    end else begin
                        det_cnt <= det_cnt + 1'b1;
                    end
                end
                L_UP: begin
                    if (!all_ok) begin
                        state   <= L_DETECT;
                        det_cnt <= '0;
                        link_up <= 1'b0;
                    end
                end
                default: state <= L_HELD;
            endcase
        end
    end

endmodule

// File: rtl/pcie_link_reset_seq.sv
// Board PERST_n to staggered per-link resets and lane enables.
// Global FSM walks WAIT then one release slot per link, then RUN.
module pcie_link_reset_seq
    import pcie_seq_pkg::*;
#(
    parameter int NUM_LINKS     = 1,
    parameter int LINK_WIDTH    = 1,
    parameter int T_PERST_CYC   = 16,
    parameter int T_STAGGER_CYC = 4,
    parameter int DET_CYC       = 8
) (
    input  logic                             CLK,
    input  logic                             PERST_n,
    input  logic [NUM_LINKS-1:0]             link_en,
    input  logic [NUM_LINKS*WSEL_W-1:0]      width_sel,
    input  logic [NUM_LINKS-1:0]             hot_rst_req,
    input  logic [NUM_LINKS*LINK_WIDTH-1:0]  rx_valid,
    output logic [NUM_LINKS-1:0]             link_perst_n,
    output logic [NUM_LINKS*LINK_WIDTH-1:0]  lane_en,
    output logic [NUM_LINKS-1:0]             link_up,
    output logic                             seq_done
);

    localparam int CMAX0 = (T_PERST_CYC > T_STAGGER_CYC) ? T_PERST_CYC : T_STAGGER_CYC;
    localparam int CMAX  = (CMAX0 > DET_CYC) ? CMAX0 : DET_CYC;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int SW    = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

    localparam logic [CW-1:0] WAIT_LAST = CW'(T_PERST_CYC - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(T_STAGGER_CYC - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_LINKS - 1);

    gstate_t              gstate;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        slot;
    logic [NUM_LINKS-1:0] rel;
    logic                 wait_done;
    logic                 slot_adv;
    logic                 run;

    assign wait_done = (gstate == G_WAIT) && (cnt >= WAIT_LAST);
    assign slot_adv  = (gstate == G_REL) && (slot != SLOT_LAST) && (cnt >= STAG_LAST);
    assign run       = (gstate == G_RUN);

    // Release pulses land on the same edge the global FSM advances.
    always_comb begin
        rel = '0;
        for (int k = 0; k < NUM_LINKS; k++)
            rel[k] = ((k == 0) && wait_done) || (slot_adv && (k == int'(slot) + 1));
    end

    always_ff @(posedge CLK or negedge PERST_n) begin
        if (!PERST_n) begin
            gstate   <= G_RST;
            cnt      <= '0;
            slot     <= '0;
            seq_done <= 1'b0;
        end else begin
            unique case (gstate)
                G_RST: begin
                    gstate <= G_WAIT;
                    cnt    <= CW'(1);
                end
                G_WAIT: begin
                    if (wait_done) begin
                        gstate <= G_REL;
                        cnt    <= '0;
                        slot   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                G_REL: begin
                    if (slot == SLOT_LAST) begin
                        gstate   <= G_RUN;
                        seq_done <= 1'b1;
                    end else if (slot_adv) begin
                        slot <= slot + 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                G_RUN:   gstate <= G_RUN;
                default: gstate <= G_RST;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
        pcie_link_fsm #(
            .LINK_WIDTH    (LINK_WIDTH),
            .T_STAGGER_CYC (T_STAGGER_CYC),
            .DET_CYC       (DET_CYC),
            .CW            (CW)
        ) u_link (
            .clk          (CLK),
            .rst_n        (PERST_n),
            .link_en      (link_en[k]),
            .hot_rst_req  (hot_rst_req[k]),
            .rel_req      (rel[k]),
            .run          (run),
            .width_sel    (width_sel[k*WSEL_W +: WSEL_W]),
            .rx_valid     (rx_valid[k*LINK_WIDTH +: LINK_WIDTH]),
            .link_perst_n (link_perst_n[k]),
            .lane_en      (lane_en[k*LINK_WIDTH +: LINK_WIDTH]),
            .link_up      (link_up[k])
        );
    end

endmodule
